// File: rtl/axi_grid_sni_mt_pkg.sv
// Shared AXI and grid channel types for the multi-outstanding slave network interface.
package axi_grid_sni_mt_pkg;

  localparam int unsigned AXI_ID_W            = 4;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned GRID_ID_W           = 4;
  localparam int unsigned GRID_TAG_W          = 6;
  localparam int unsigned SNI_NUM_OUTSTANDING = 8;

  typedef logic [AXI_ID_W-1:0]   axi_id_t;
  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [GRID_ID_W-1:0]  grid_id_t;
  typedef logic [GRID_TAG_W-1:0] grid_tag_t;

  typedef struct packed {axi_id_t id; addr_t addr; logic [7:0] len;} axi_ax_t;
  typedef struct packed {data_t data; logic [3:0] strb; logic last;} axi_w_t;
  typedef struct packed {axi_id_t id; logic [1:0] resp;} axi_b_t;
  typedef struct packed {axi_id_t id; data_t data; logic [1:0] resp; logic last;} axi_r_t;

  typedef struct packed {
    logic aw_valid; axi_ax_t aw;
    logic w_valid;  axi_w_t  w;
    logic b_ready;
    logic ar_valid; axi_ax_t ar;
    logic r_ready;
  } sni_req_t;

  typedef struct packed {
    logic aw_ready; logic w_ready;
    logic b_valid;  axi_b_t b;
    logic ar_ready;
    logic r_valid;  axi_r_t r;
  } sni_resp_t;

  typedef struct packed {grid_id_t dst; grid_id_t src; grid_tag_t tag; addr_t addr; logic [7:0] len;} grid_aw_chan_t;
  typedef grid_aw_chan_t grid_ar_chan_t;
  typedef struct packed {grid_id_t dst; grid_id_t src; data_t data; logic [3:0] strb; logic last;} grid_w_chan_t;
  typedef struct packed {grid_id_t dst; grid_id_t src; grid_tag_t tag; logic [1:0] resp;} grid_b_chan_t;
  typedef struct packed {grid_id_t dst; grid_id_t src; grid_tag_t tag; data_t data; logic [1:0] resp; logic last;} grid_r_chan_t;

  // A tag with bits above the table index can never have been allocated.
  function automatic logic tag_in_range(input grid_tag_t tag, input int unsigned num);
    return 32'(tag) < num;
  endfunction

endpackage

// File: rtl/axi_grid_sni_mt_tag_table.sv
// Tag table: lowest-index free-list allocator with a per-tag valid bit and stored AXI id.
module axi_grid_sni_tag_table #(
  parameter  int unsigned NUM  = 8,
  parameter  type         id_t = logic [3:0],
  localparam int unsigned TW   = $clog2(NUM)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          alloc_i,
  input  id_t           alloc_id_i,
  input  logic          free_i,
  input  logic [TW-1:0] free_tag_i,
  input  logic [TW-1:0] lookup_tag_i,
  output logic [TW-1:0] tag_o,
  output logic          free_o,
  output id_t           id_o,
  output logic          hit_o
);

  logic [NUM-1:0] valid_q, valid_d;
  id_t            id_q [NUM];

  // Priority encoder: scanning downwards leaves the lowest free index.
  always_comb begin
    tag_o  = '0;
    free_o = 1'b0;
    for (int i = int'(NUM) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        tag_o  = TW'(i);
        free_o = 1'b1;
      end
    end
  end

  assign id_o  = id_q[lookup_tag_i];
  assign hit_o = valid_q[lookup_tag_i];

  // The freed tag is still marked busy this cycle, so alloc never picks it.
  always_comb begin
    valid_d = valid_q;
    if (free_i) valid_d[free_tag_i] = 1'b0;
    if (alloc_i) valid_d[tag_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NUM); i++) id_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      if (alloc_i) id_q[tag_o] <= alloc_id_i;
    end
  end

endmodule

// File: rtl/axi_grid_sni_mt.sv
// Multi-outstanding slave NI: tags AXI AW/AR onto the grid and restores AXI ids on B/R.
module axi_grid_sni_mt
  import axi_grid_sni_mt_pkg::*;
#(
  parameter grid_id_t    NI_ID           = '0,
  parameter int unsigned NUM_OUTSTANDING = SNI_NUM_OUTSTANDING,
  parameter int unsigned DST_LSB         = 28
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  sni_req_t      req_i,
  output sni_resp_t     resp_o,
  output grid_aw_chan_t grid_aw_o,
  output logic          grid_aw_valid_o,
  input  logic          grid_aw_ready_i,
  output grid_w_chan_t  grid_w_o,
  output logic          grid_w_valid_o,
  input  logic          grid_w_ready_i,
  output grid_ar_chan_t grid_ar_o,
  output logic          grid_ar_valid_o,
  input  logic          grid_ar_ready_i,
  input  grid_b_chan_t  grid_b_i,
  input  logic          grid_b_valid_i,
  output logic          grid_b_ready_o,
  input  grid_r_chan_t  grid_r_i,
  input  logic          grid_r_valid_i,
  output logic          grid_r_ready_o,
  output logic          err_o
);

  localparam int unsigned TW = $clog2(NUM_OUTSTANDING);
  localparam int unsigned CW = TW + 1;

  logic          run_q, err_q;
  logic          wt_free_s, wt_hit_s, rt_free_s, rt_hit_s;
  logic [TW-1:0] wt_tag_s, rt_tag_s;
  axi_id_t       wt_id_s, rt_id_s;
  grid_aw_chan_t aw_stage_q;
  grid_ar_chan_t ar_stage_q;
  logic          aw_stage_valid_q, ar_stage_valid_q;
  grid_id_t      wdst_q [NUM_OUTSTANDING];
  logic [TW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] wcnt_q;
  axi_b_t        b_q;
  axi_r_t        r_q;
  logic          b_valid_q, r_valid_q;
  logic [TW-1:0] b_tag_q, r_tag_q;
  logic          unused_s;

  // Readies stay low until the first clock after reset release.
  wire aw_ready_s   = run_q & wt_free_s & (!aw_stage_valid_q | grid_aw_ready_i);
  wire ar_ready_s   = run_q & rt_free_s & (!ar_stage_valid_q | grid_ar_ready_i);
  wire aw_hs_s      = req_i.aw_valid & aw_ready_s;
  wire ar_hs_s      = req_i.ar_valid & ar_ready_s;
  wire aw_issue_s   = aw_stage_valid_q & grid_aw_ready_i;
  wire ar_issue_s   = ar_stage_valid_q & grid_ar_ready_i;
  wire wfifo_ne_s   = wcnt_q != '0;
  wire w_ready_s    = run_q & wfifo_ne_s & grid_w_ready_i;
  wire w_pop_s      = req_i.w_valid & w_ready_s & req_i.w.last;
  wire b_ready_s    = run_q & (!b_valid_q | req_i.b_ready);
  wire r_ready_s    = run_q & (!r_valid_q | req_i.r_ready);
  wire grid_b_hs_s  = grid_b_valid_i & b_ready_s;
  wire grid_r_hs_s  = grid_r_valid_i & r_ready_s;
  wire b_known_s    = wt_hit_s & tag_in_range(grid_b_i.tag, NUM_OUTSTANDING);
  wire r_known_s    = rt_hit_s & tag_in_range(grid_r_i.tag, NUM_OUTSTANDING);
  wire b_axi_hs_s   = b_valid_q & req_i.b_ready;
  wire r_axi_hs_s   = r_valid_q & req_i.r_ready;

  assign unused_s = ^{grid_b_i.dst, grid_b_i.src, grid_r_i.dst, grid_r_i.src};

  axi_grid_sni_tag_table #(.NUM(NUM_OUTSTANDING), .id_t(axi_id_t)) u_wtag (
    .clk_i, .arst_i, .alloc_i(aw_hs_s), .alloc_id_i(req_i.aw.id),
    .free_i(b_axi_hs_s), .free_tag_i(b_tag_q), .lookup_tag_i(grid_b_i.tag[TW-1:0]),
    .tag_o(wt_tag_s), .free_o(wt_free_s), .id_o(wt_id_s), .hit_o(wt_hit_s)
  );

  axi_grid_sni_tag_table #(.NUM(NUM_OUTSTANDING), .id_t(axi_id_t)) u_rtag (
    .clk_i, .arst_i, .alloc_i(ar_hs_s), .alloc_id_i(req_i.ar.id),
    .free_i(r_axi_hs_s & r_q.last), .free_tag_i(r_tag_q), .lookup_tag_i(grid_r_i.tag[TW-1:0]),
    .tag_o(rt_tag_s), .free_o(rt_free_s), .id_o(rt_id_s), .hit_o(rt_hit_s)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      run_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      err_q <= err_q | (grid_b_hs_s & !b_known_s) | (grid_r_hs_s & !r_known_s);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      aw_stage_valid_q <= 1'b0;
      aw_stage_q       <= '0;
      ar_stage_valid_q <= 1'b0;
      ar_stage_q       <= '0;
    end else begin
      if (aw_hs_s) begin
        aw_stage_valid_q <= 1'b1;
        aw_stage_q <= '{dst: req_i.aw.addr[DST_LSB +: GRID_ID_W], src: NI_ID,
                        tag: GRID_TAG_W'(wt_tag_s), addr: req_i.aw.addr, len: req_i.aw.len};
      end else if (aw_issue_s) begin
        aw_stage_valid_q <= 1'b0;
      end
      if (ar_hs_s) begin
        ar_stage_valid_q <= 1'b1;
        ar_stage_q <= '{dst: req_i.ar.addr[DST_LSB +: GRID_ID_W], src: NI_ID,
                        tag: GRID_TAG_W'(rt_tag_s), addr: req_i.ar.addr, len: req_i.ar.len};
      end else if (ar_issue_s) begin
        ar_stage_valid_q <= 1'b0;
      end
    end
  end

  // W-dst FIFO: one entry per issued AW, retired by the matching wlast beat.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wcnt_q   <= '0;
      for (int i = 0; i < int'(NUM_OUTSTANDING); i++) wdst_q[i] <= '0;
    end else begin
      if (aw_issue_s) begin
        wdst_q[wr_ptr_q] <= aw_stage_q.dst;
        wr_ptr_q         <= wr_ptr_q + TW'(1);
      end
      if (w_pop_s) rd_ptr_q <= rd_ptr_q + TW'(1);
      wcnt_q <= wcnt_q + CW'(aw_issue_s) - CW'(w_pop_s);
    end
  end

  // Response registers; beats with an unallocated tag are consumed and dropped.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      b_valid_q <= 1'b0;
      b_q       <= '0;
      b_tag_q   <= '0;
      r_valid_q <= 1'b0;
      r_q       <= '0;
      r_tag_q   <= '0;
    end else begin
      if (grid_b_hs_s && b_known_s) begin
        b_valid_q <= 1'b1;
        b_q       <= '{id: wt_id_s, resp: grid_b_i.resp};
        b_tag_q   <= grid_b_i.tag[TW-1:0];
      end else if (b_axi_hs_s) begin
        b_valid_q <= 1'b0;
      end
      if (grid_r_hs_s && r_known_s) begin
        r_valid_q <= 1'b1;
        r_q       <= '{id: rt_id_s, data: grid_r_i.data, resp: grid_r_i.resp, last: grid_r_i.last};
        r_tag_q   <= grid_r_i.tag[TW-1:0];
      end else if (r_axi_hs_s) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = aw_ready_s;
    resp_o.w_ready  = w_ready_s;
    resp_o.ar_ready = ar_ready_s;
    resp_o.b_valid  = b_valid_q;
    resp_o.b        = b_q;
    resp_o.r_valid  = r_valid_q;
    resp_o.r        = r_q;
  end

  assign grid_aw_o       = aw_stage_q;
  assign grid_aw_valid_o = aw_stage_valid_q;
  assign grid_ar_o       = ar_stage_q;
  assign grid_ar_valid_o = ar_stage_valid_q;
  assign grid_w_o        = '{dst: wdst_q[rd_ptr_q], src: NI_ID, data: req_i.w.data,
                             strb: req_i.w.strb, last: req_i.w.last};
  assign grid_w_valid_o  = run_q & req_i.w_valid & wfifo_ne_s;
  assign grid_b_ready_o  = b_ready_s;
  assign grid_r_ready_o  = r_ready_s;
  assign err_o           = err_q;

endmodule

// File: tb/tb_axi_grid_sni_mt.sv
// Directed self-checking bench for axi_grid_sni_mt with hand-computed expectations.
module tb_axi_grid_sni_mt;
  import axi_grid_sni_mt_pkg::*;

  localparam grid_id_t NI = 4'd2;

  logic clk = 1'b0;
  logic arst_i = 1'b1;
  always #5 clk = ~clk;

  sni_req_t      req;
  sni_resp_t     resp, snap;
  grid_aw_chan_t gaw;
  grid_ar_chan_t gar;
  grid_w_chan_t  gw;
  grid_b_chan_t  gb;
  grid_r_chan_t  gr;
  logic gaw_valid, gaw_ready, gw_valid, gw_ready, gar_valid, gar_ready;
  logic gb_valid, gb_ready, gr_valid, gr_ready, err;

  int n_cmp = 0;
  int n_bad = 0;
  grid_aw_chan_t aw_mon[$];
  grid_ar_chan_t ar_mon[$];
  grid_id_t      wdst_mon[$];
  grid_aw_chan_t aw_snap, mon_aw;
  grid_ar_chan_t mon_ar;

  axi_grid_sni_mt #(.NI_ID(NI), .NUM_OUTSTANDING(8), .DST_LSB(28)) dut (
    .clk_i(clk), .arst_i(arst_i), .req_i(req), .resp_o(resp),
    .grid_aw_o(gaw), .grid_aw_valid_o(gaw_valid), .grid_aw_ready_i(gaw_ready),
    .grid_w_o(gw), .grid_w_valid_o(gw_valid), .grid_w_ready_i(gw_ready),
    .grid_ar_o(gar), .grid_ar_valid_o(gar_valid), .grid_ar_ready_i(gar_ready),
    .grid_b_i(gb), .grid_b_valid_i(gb_valid), .grid_b_ready_o(gb_ready),
    .grid_r_i(gr), .grid_r_valid_i(gr_valid), .grid_r_ready_o(gr_ready),
    .err_o(err)
  );

  // Grid-side monitors: inputs are stable from negedge to posedge, so a grant seen here is taken at the next edge.
  always @(negedge clk) begin
    #2;
    if (!arst_i) begin
      if (gaw_valid && gaw_ready) aw_mon.push_back(gaw);
      if (gar_valid && gar_ready) ar_mon.push_back(gar);
      if (gw_valid && gw_ready) wdst_mon.push_back(gw.dst);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic hs_rdy(input int ch);
    case (ch)
      0: return resp.aw_ready;
      1: return resp.w_ready;
      2: return resp.ar_ready;
      3: return gb_ready;
      4: return gr_ready;
      5: return resp.b_valid;
      6: return resp.r_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Entered at a negedge with the request already driven; returns at the negedge after the handshake.
  task automatic wait_hs(input int ch, input string tag);
    bit hs = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (hs_rdy(ch)) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    snap = resp;
    check_val(tag, 64'(hs), 64'd1);
    if (hs) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    arst_i = 1'b1;
    req = '0; gb = '0; gr = '0;
    gb_valid = 1'b0; gr_valid = 1'b0;
    gaw_ready = 1'b1; gw_ready = 1'b1; gar_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_ctrl", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid,
                                gaw_valid, gw_valid, gar_valid, gb_ready, gr_ready}), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    arst_i = 1'b0;
    aw_mon.delete(); ar_mon.delete(); wdst_mon.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_aw(input axi_id_t id, input addr_t addr);
    req.aw = '{id: id, addr: addr, len: 8'd0};
    req.aw_valid = 1'b1;
    wait_hs(0, "aw_hs");
    req.aw_valid = 1'b0;
  endtask

  task automatic do_ar(input axi_id_t id, input addr_t addr);
    req.ar = '{id: id, addr: addr, len: 8'd0};
    req.ar_valid = 1'b1;
    wait_hs(2, "ar_hs");
    req.ar_valid = 1'b0;
  endtask

  task automatic do_w(input data_t data, input logic last);
    req.w = '{data: data, strb: 4'hF, last: last};
    req.w_valid = 1'b1;
    wait_hs(1, "w_hs");
    req.w_valid = 1'b0;
  endtask

  task automatic send_gb(input grid_tag_t tag);
    gb = '{dst: NI, src: 4'd3, tag: tag, resp: 2'd0};
    gb_valid = 1'b1;
    wait_hs(3, "gb_hs");
    gb_valid = 1'b0;
  endtask

  task automatic send_gr(input grid_tag_t tag, input data_t data, input logic last);
    gr = '{dst: NI, src: 4'd3, tag: tag, data: data, resp: 2'd0, last: last};
    gr_valid = 1'b1;
    wait_hs(4, "gr_hs");
    gr_valid = 1'b0;
  endtask

  task automatic recv_b();
    req.b_ready = 1'b1;
    wait_hs(5, "b_hs");
    req.b_ready = 1'b0;
  endtask

  task automatic recv_r();
    req.r_ready = 1'b1;
    wait_hs(6, "r_hs");
    req.r_ready = 1'b0;
  endtask

  task automatic pop_aw(output grid_aw_chan_t c);
    for (int i = 0; i < 20 && aw_mon.size() == 0; i++) @(negedge clk);
    check_val("aw_seen", 64'(aw_mon.size() != 0), 64'd1);
    c = (aw_mon.size() != 0) ? aw_mon.pop_front() : '0;
  endtask

  initial begin
    do_reset();

    // Single write: 0x3000_0000 id 5 -> dst 3, tag 0; B tag 0 returns id 5.
    do_aw(4'd5, 32'h3000_0000);
    pop_aw(mon_aw);
    check_val("w1_aw_dst", 64'(mon_aw.dst), 64'd3);
    check_val("w1_aw_src", 64'(mon_aw.src), 64'(NI));
    check_val("w1_aw_tag", 64'(mon_aw.tag), 64'd0);
    do_w(32'h1111_0000, 1'b1);
    check_val("w1_w_dst", 64'(wdst_mon.size() == 1 ? wdst_mon[0] : 4'hF), 64'd3);
    wdst_mon.delete();
    send_gb(6'd0);
    recv_b();
    check_val("w1_b_id", 64'(snap.b.id), 64'd5);
    check_val("w1_err", 64'(err), 64'd0);

    // Fill all eight read tags; the ninth AR must stall.
    for (int i = 0; i < 8; i++) do_ar(axi_id_t'(i), 32'h7000_0000);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mon_ar = (ar_mon.size() != 0) ? ar_mon.pop_front() : '1;
      check_val("ar_fill_tag", 64'(mon_ar.tag), 64'(i));
    end
    req.ar_valid = 1'b1;
    #1;
    check_val("ar_full_ready", 64'(resp.ar_ready), 64'd0);
    @(negedge clk);
    req.ar_valid = 1'b0;
    send_gr(6'd2, 32'hCAFE_0002, 1'b1);
    recv_r();
    check_val("r2_id", 64'(snap.r.id), 64'd2);
    check_val("r2_data", 64'(snap.r.data), 64'hCAFE_0002);
    #1;
    check_val("ar_freed_ready", 64'(resp.ar_ready), 64'd1);
    @(negedge clk);
    do_ar(4'd9, 32'h7000_0000);
    repeat (2) @(negedge clk);
    mon_ar = (ar_mon.size() != 0) ? ar_mon.pop_front() : '1;
    check_val("ar_realloc_tag", 64'(mon_ar.tag), 64'd2);
    send_gr(6'd5, 32'hBEEF_0005, 1'b0);
    recv_r();
    check_val("r5_id", 64'(snap.r.id), 64'd5);
    check_val("r5_last", 64'(snap.r.last), 64'd0);
    #1;
    check_val("r_nonlast_keeps", 64'(resp.ar_ready), 64'd0);
    @(negedge clk);

    // Two AWs under grid AW backpressure, then two 4-beat bursts.
    do_reset();
    gaw_ready = 1'b0;
    do_aw(4'd6, 32'h1000_0000);
    req.aw = '{id: 4'd7, addr: 32'h4000_0000, len: 8'd3};
    req.aw_valid = 1'b1;
    req.w = '{data: 32'h0, strb: 4'hF, last: 1'b0};
    req.w_valid = 1'b1;
    #1;
    aw_snap = gaw;
    check_val("bp_first_dst", 64'(aw_snap.dst), 64'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("bp_valid", 64'(gaw_valid), 64'd1);
      check_val("bp_stable", 64'(gaw == aw_snap), 64'd1);
      check_val("bp_aw_ready", 64'(resp.aw_ready), 64'd0);
      check_val("bp_w_stall", 64'(resp.w_ready), 64'd0);
      @(negedge clk);
    end
    gaw_ready = 1'b1;
    do_aw(4'd7, 32'h4000_0000);
    for (int i = 0; i < 8; i++) do_w(data_t'(i), (i == 3) || (i == 7));
    for (int i = 0; i < 8; i++) begin
      check_val("w_beat_dst", 64'(i < wdst_mon.size() ? wdst_mon[i] : 4'hF), (i < 4) ? 64'd1 : 64'd4);
    end
    pop_aw(mon_aw);
    check_val("aw_a_tag", 64'(mon_aw.tag), 64'd0);
    pop_aw(mon_aw);
    check_val("aw_b_tag", 64'(mon_aw.tag), 64'd1);
    check_val("aw_b_dst", 64'(mon_aw.dst), 64'd4);

    // Same-cycle B free of tag 0 with AW alloc: new AW gets tag 2, the next one tag 0.
    send_gb(6'd0);
    req.b_ready = 1'b1;
    req.aw = '{id: 4'd3, addr: 32'h5000_0000, len: 8'd0};
    req.aw_valid = 1'b1;
    #1;
    check_val("same_b_valid", 64'(resp.b_valid), 64'd1);
    check_val("same_aw_ready", 64'(resp.aw_ready), 64'd1);
    check_val("same_b_id", 64'(resp.b.id), 64'd6);
    @(posedge clk);
    @(negedge clk);
    req.b_ready = 1'b0;
    req.aw_valid = 1'b0;
    pop_aw(mon_aw);
    check_val("same_aw_tag", 64'(mon_aw.tag), 64'd2);
    do_aw(4'd4, 32'h6000_0000);
    pop_aw(mon_aw);
    check_val("next_aw_tag", 64'(mon_aw.tag), 64'd0);

    // Unallocated tag 6: consumed, no AXI B, sticky error until reset.
    send_gb(6'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bad_no_b", 64'(resp.b_valid), 64'd0);
      check_val("bad_err", 64'(err), 64'd1);
      @(negedge clk);
    end
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
